// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode seven-segment display.
// Drives a shared BCD decoder plus one-hot digit enables with blanking, double buffering and leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    lzb,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state, next_state;
    logic [CNT_W-1:0]        cnt, next_cnt;
    logic [IDX_W-1:0]        idx, next_idx;
    logic [4*NUM_DIGITS-1:0] disp, next_disp, pend_buf;
    logic [3:0]              next_bcd;
    logic [NUM_DIGITS-1:0]   next_digit_en;
    logic                    next_frame_done;
    logic                    blank_slot, blank_now;
    logic                    transfer;
    logic [NUM_DIGITS-1:0]   lead_zero;

    // lead_zero[k]: digit k and every higher digit of the display buffer are zero
    always_comb begin : lz_scan
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (disp[4*k +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end
    end

    always_comb begin
        // The display buffer only swaps at a frame boundary, or any time the display is dark
        transfer        = pending && (frame_done || !en);
        next_disp       = transfer ? pend_buf : disp;
        next_state      = state;
        next_cnt        = cnt;
        next_idx        = idx;
        next_bcd        = bcd;
        next_digit_en   = '0;
        next_frame_done = 1'b0;
        blank_now       = blank_slot;

        if (!en) begin
            next_state = BLANK;
            next_cnt   = '0;
            next_idx   = '0;
        end else begin
            if (cnt == CNT_LAST) begin
                next_cnt = '0;
                next_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                next_cnt = cnt + 1'b1;
            end
            next_state = (next_cnt < CNT_SHOW) ? BLANK : SHOW;

            case (state)
                BLANK: begin
                    if (cnt == '0)
                        next_bcd = next_disp[4*idx +: 4];
                end
                SHOW: begin
                    if (cnt == CNT_SHOW)
                        blank_now = lzb && (idx != '0) && lead_zero[idx];
                    if (!blank_now)
                        next_digit_en[idx] = 1'b1;
                    next_frame_done = (cnt == CNT_LAST) && (idx == IDX_LAST);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            pend_buf   <= '0;
            pending    <= 1'b0;
            blank_slot <= 1'b0;
            bcd        <= '0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            idx        <= next_idx;
            disp       <= next_disp;
            if (load)
                pend_buf <= value_in;
            pending    <= load || (pending && !transfer);
            blank_slot <= blank_now;
            bcd        <= next_bcd;
            digit_en   <= next_digit_en;
            frame_done <= next_frame_done;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed tables, hand sequences and a
// randomized run compared against a slot/phase arithmetic reference model.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          lzb = 1'b0;
    logic [4*N-1:0] value_in = '0;
    logic          load = 1'b0;
    logic [3:0]    bcd;
    logic [N-1:0]  digit_en;
    logic          frame_done;
    logic          pending;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lzb(lzb), .value_in(value_in),
        .load(load), .bcd(bcd), .digit_en(digit_en), .frame_done(frame_done),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: position in the frame is derived from a running cycle count t
    int            m_t = 0;
    logic [4*N-1:0] m_disp = '0, m_pbuf = '0;
    logic          m_pend = 1'b0, m_fd = 1'b0, m_blank = 1'b0;
    logic [3:0]    m_bcd = '0;
    logic [N-1:0]  m_de = '0;
    logic          prev_fd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic          xfer;
        logic [4*N-1:0] dn;
        int            slot, ph;
        if (!rst_n) begin
            m_t = 0; m_disp = '0; m_pbuf = '0; m_pend = 0; m_fd = 0;
            m_blank = 0; m_bcd = '0; m_de = '0;
        end else begin
            xfer = m_pend && (m_fd || !en);
            dn   = xfer ? m_pbuf : m_disp;
            if (!en) begin
                m_t = 0; m_de = '0; m_fd = 0;
            end else begin
                slot = (m_t / R) % N;
                ph   = m_t % R;
                if (ph == 0) m_bcd = 4'(dn >> (4*slot));
                if (ph == B) m_blank = lzb && (slot != 0) && ((dn >> (4*slot)) == 0);
                m_de = (ph >= B && !m_blank) ? (N'(1) << slot) : '0;
                m_fd = (ph == R-1) && (slot == N-1);
                m_t  = (m_t + 1) % (N*R);
            end
            m_disp = dn;
            if (load) m_pbuf = value_in;
            m_pend = load || (m_pend && !xfer);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_bcd", bcd, m_bcd);
        check("model_digit_en", digit_en, m_de);
        check("model_frame_done", frame_done, m_fd);
        check("model_pending", pending, m_pend);
        check("onehot", ($countones(digit_en) <= 1), 1);
        check("fd_not_consecutive", (prev_fd && frame_done), 0);
        prev_fd = frame_done;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        while (k < 40 && frame_done !== 1'b1) begin
            tick();
            k++;
        end
        check("wait_frame_done_timeout", frame_done, 1);
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] bcd;
        logic [3:0] de;
        logic       fd;
        logic       pend;
    } chk_t;

    chk_t tbl[13];

    initial begin
        int cyc, n0, n1, nbad;
        tbl[0]  = '{1,  4'd0, 4'b0000, 1'b0, 1'b1};
        tbl[1]  = '{3,  4'd0, 4'b0001, 1'b0, 1'b1};
        tbl[2]  = '{8,  4'd0, 4'b0001, 1'b0, 1'b1};
        tbl[3]  = '{9,  4'd0, 4'b0000, 1'b0, 1'b1};
        tbl[4]  = '{11, 4'd0, 4'b0010, 1'b0, 1'b1};
        tbl[5]  = '{32, 4'd0, 4'b1000, 1'b1, 1'b1};
        tbl[6]  = '{33, 4'd1, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{35, 4'd1, 4'b0001, 1'b0, 1'b0};
        tbl[8]  = '{43, 4'd2, 4'b0010, 1'b0, 1'b0};
        tbl[9]  = '{51, 4'd3, 4'b0100, 1'b0, 1'b0};
        tbl[10] = '{59, 4'd4, 4'b1000, 1'b0, 1'b0};
        tbl[11] = '{64, 4'd4, 4'b1000, 1'b1, 1'b0};
        tbl[12] = '{65, 4'd1, 4'b0000, 1'b0, 1'b0};

        // Reset state
        rst_n = 0; en = 1;
        ticks(2);
        check("reset_bcd", bcd, 0);
        check("reset_digit_en", digit_en, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_pending", pending, 0);

        // Reset then scan, load 4321 in the first cycle
        rst_n = 1; load = 1; value_in = 16'h4321;
        tick();
        load = 0;
        cyc = 1;
        for (int i = 0; i < 13; i++) begin
            while (cyc < tbl[i].cyc) begin
                tick();
                cyc++;
            end
            check($sformatf("tbl%0d_bcd", i), bcd, tbl[i].bcd);
            check($sformatf("tbl%0d_digit_en", i), digit_en, tbl[i].de);
            check($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].fd);
            check($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
        end

        // Tear-free update: 9999 loaded mid-frame while 1234 is shown
        load = 1; value_in = 16'h1234; tick(); load = 0;
        wait_fd(); tick();
        check("tf_start_bcd", bcd, 4);
        ticks(10);
        check("tf_d1_bcd", bcd, 3);
        check("tf_d1_en", digit_en, 4'b0010);
        load = 1; value_in = 16'h9999; tick(); load = 0;
        check("tf_pending_set", pending, 1);
        ticks(7);
        check("tf_d2_bcd", bcd, 2);
        check("tf_d2_en", digit_en, 4'b0100);
        check("tf_d2_pending", pending, 1);
        ticks(13);
        check("tf_fd", frame_done, 1);
        check("tf_d3_bcd", bcd, 1);
        tick();
        check("tf_new_bcd", bcd, 9);
        check("tf_pending_clr", pending, 0);
        ticks(8);
        check("tf_new_d1_bcd", bcd, 9);

        // Load exactly on the frame_done cycle while another value is pending
        load = 1; value_in = 16'h7777; tick(); load = 0;
        wait_fd();
        load = 1; value_in = 16'h5555; tick(); load = 0;
        check("sim_first_bcd", bcd, 7);
        check("sim_pending_kept", pending, 1);
        wait_fd();
        check("sim_last_bcd", bcd, 7);
        tick();
        check("sim_next_bcd", bcd, 5);
        check("sim_pending_clr", pending, 0);

        // Leading-zero blanking with 0050 then 0000
        lzb = 1;
        for (int pass = 0; pass < 2; pass++) begin
            load = 1; value_in = (pass == 0) ? 16'h0050 : 16'h0000; tick(); load = 0;
            wait_fd(); tick();
            n0 = 0; n1 = 0; nbad = 0;
            for (int i = 0; i < 31; i++) begin
                tick();
                if (digit_en == 4'b0001) begin
                    n0++;
                    check("lzb_d0_bcd", bcd, 0);
                end
                if (digit_en == 4'b0010) begin
                    n1++;
                    check("lzb_d1_bcd", bcd, 5);
                end
                if (digit_en == 4'b0100 || digit_en == 4'b1000) nbad++;
            end
            check("lzb_d0_cycles", n0, 6);
            check("lzb_d1_cycles", n1, (pass == 0) ? 6 : 0);
            check("lzb_high_lit", nbad, 0);
        end
        lzb = 0;

        // Enable drop during digit 2 SHOW, then reset mid-SHOW
        load = 1; value_in = 16'h1234; tick(); load = 0;
        wait_fd(); tick();
        ticks(19);
        check("en_d2_before", digit_en, 4'b0100);
        en = 0; tick();
        check("en_off_digit_en", digit_en, 0);
        check("en_off_fd", frame_done, 0);
        ticks(2);
        en = 1;
        tick(); check("en_back_1", digit_en, 0);
        tick(); check("en_back_2", digit_en, 0);
        tick(); check("en_back_3", digit_en, 4'b0001);
        check("en_back_bcd", bcd, 4);
        ticks(3);
        rst_n = 0; tick();
        check("rst_mid_bcd", bcd, 0);
        check("rst_mid_digit_en", digit_en, 0);
        check("rst_mid_fd", frame_done, 0);
        check("rst_mid_pending", pending, 0);
        rst_n = 1;

        // Randomized run against the reference model
        for (int i = 0; i < 1000; i++) begin
            rst_n    = ($urandom_range(199) != 0);
            if ($urandom_range(49) == 0) en = ~en;
            lzb      = 1'($urandom_range(1));
            load     = ($urandom_range(7) == 0);
            value_in = 16'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
